// File: rtl/serdesphy_manchester_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : serdesphy_manchester_decoder_pipe
// Description : Streaming Manchester (biphase) decoder for the SerDes PHY RX
//               path. One decode stage (S1) feeds an output FIFO; invalid
//               pairs are flagged per bit, errored words are counted and may
//               optionally be dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module serdesphy_manchester_decoder_pipe #(
  parameter int DATA_W        = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int POLARITY      = 0,
  parameter int DROP_ON_ERROR = 0,
  parameter int CNT_W         = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic [2*DATA_W-1:0]               in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic [DATA_W-1:0]                 out_err_mask,
  output logic                              out_error,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic [CNT_W-1:0]                  err_count,
  input  logic                              err_count_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [LVL_W:0]   c_depth   = (LVL_W+1)'(FIFO_DEPTH);

  // Combinational pair decode of the incoming word
  logic [DATA_W-1:0] w_dec_data;
  logic [DATA_W-1:0] w_dec_mask;

  for (genvar i = 0; i < DATA_W; i++) begin : g_pair
    logic [1:0] w_pair;
    assign w_pair        = in_data[2*i+1 -: 2];
    // 00 and 11 carry no transition: flag and force the data bit to 0
    assign w_dec_mask[i] = (w_pair[1] == w_pair[0]);
    assign w_dec_data[i] = (POLARITY == 0) ? (w_pair == 2'b01) : (w_pair == 2'b10);
  end

  // Pipeline / FIFO state
  logic                  r_s1_valid;
  logic [DATA_W-1:0]     r_s1_data;
  logic [DATA_W-1:0]     r_s1_mask;
  logic [2*DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic [CNT_W-1:0]      r_err_count;

  logic                  w_accept;
  logic                  w_s1_err;
  logic                  w_push;
  logic                  w_pop;
  logic [2*DATA_W-1:0]   w_head;

  // Room is reserved for the word already sitting in S1, so an accepted
  // word always finds a free FIFO slot one edge later.
  assign in_ready  = rst_n && enable &&
                     (({1'b0, r_level} + {{LVL_W{1'b0}}, r_s1_valid}) < c_depth);
  assign w_accept  = in_valid && in_ready;
  assign w_s1_err  = |r_s1_mask;
  assign w_push    = r_s1_valid && !((DROP_ON_ERROR != 0) && w_s1_err);
  assign out_valid = (r_level != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_head    = r_mem[r_rd_ptr];

  // Head is masked to zero while empty so outputs are clean after reset
  assign out_data     = out_valid ? w_head[DATA_W-1:0]        : '0;
  assign out_err_mask = out_valid ? w_head[2*DATA_W-1:DATA_W] : '0;
  assign out_error    = |out_err_mask;
  assign fifo_level   = r_level;
  assign err_count    = r_err_count;

  // S1 register: loads on accept, otherwise empties into the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mask  <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= w_dec_data;
      r_s1_mask  <= w_dec_mask;
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  // FIFO storage: no reset needed, contents are qualified by the level
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_s1_mask, r_s1_data};
    end
  end

  // FIFO pointers and occupancy; push and pop together leave level unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Saturating error counter; clear wins over a concurrent increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (err_count_clr) begin
      r_err_count <= '0;
    end else if (r_s1_valid && w_s1_err && (r_err_count != c_cnt_max)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: doc/serdesphy_manchester_decoder_pipe.md
# serdesphy_manchester_decoder_pipe

Parametrised, streaming Manchester decoder for the SerDes PHY receive path. It sits between the deserializer and the RX framer. It converts 2·DATA_W-bit biphase words into DATA_W-bit parallel data and reports per-symbol errors. It provides valid/ready flow control on both sides, an output FIFO, a selectable symbol polarity, optional dropping of errored words, and a saturating error counter. It accepts one word per clock at full throughput.

## Interface
- DATA_W, 8: decoded bits per word; encoded input is 2·DATA_W bits.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.
- POLARITY, 0: 0 → pair 10 = logic 0, 01 = logic 1; 1 → inverted (10 = 1, 01 = 0).
- DROP_ON_ERROR, 0: 1 → words with any invalid pair are counted but not written to the FIFO.
- CNT_W, 8: error counter width.

Ports:
- clk  in  1  24 MHz PHY clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  0 forces in_ready low; queued data still drains.
- in_data  in  2·DATA_W  Manchester word; pair i = {in_data[2i+1], in_data[2i]}.
- in_valid  in  1  input word present.
- in_ready  out  1  decoder can accept a word.
- out_data  out  DATA_W  decoded word at FIFO head.
- out_err_mask  out  DATA_W  bit i set = pair i invalid (00 or 11).
- out_error  out  1  OR of out_err_mask.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- fifo_level  out  clog2(FIFO_DEPTH+1)  FIFO occupancy.
- err_count  out  CNT_W  saturating count of errored words.
- err_count_clr  in  1  synchronous clear of err_count.

## Operation
- Accept: a transfer occurs on a rising edge with in_valid && in_ready.
- in_ready = enable && (fifo_level + s1_valid < FIFO_DEPTH). This is combinational, and an accepted word always has guaranteed FIFO room.
- Stage 1 (S1) register: on accept, stores decoded data, err mask and s1_valid=1. Otherwise s1_valid is cleared after S1 writes to the FIFO.
- Decode per pair i: 01/10 map per POLARITY. For 00/11, data bit i = 0 and mask bit i = 1.
- FIFO write: S1 content is written on the edge after S1 loads. With DROP_ON_ERROR=1 and a nonzero mask, the word is discarded instead of written.
- FIFO read: a pop occurs on a rising edge with out_valid && out_ready. out_data, out_err_mask and out_error reflect the head entry and are stable while out_valid && !out_ready.
- Simultaneous push and pop is allowed at any level, including full, with the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- err_count increments by 1 per errored word leaving S1, whether stored or dropped, and saturates at 2^CNT_W−1.
- err_count_clr has priority: on the same edge as an increment, the result is 0 and the concurrent error is not counted.
- enable low mid-stream: the word in S1 and the FIFO contents still drain normally. No word is lost or duplicated.

## Timing
- Reset values: in_ready 0 while rst_n low, then enable-dependent; out_valid 0; out_data 0; out_err_mask 0; out_error 0; fifo_level 0; err_count 0; s1_valid 0.
- Reset asserted mid-operation: S1, FIFO and counter flush immediately (asynchronous). In-flight words are lost.
- Latency: a word accepted at edge k loads S1 at edge k. It is written to the FIFO at edge k+1, and out_valid is high after edge k+1 when the FIFO was empty. This gives 2 edges input-to-output.
- err_count updates at the same edge as the FIFO write (k+1).
- Throughput: 1 word/clock when out_ready is held high.
- No combinational path from in_valid to out_valid. in_ready depends only on registered state and enable.

## Test plan
- Basic decode (DATA_W=8, POLARITY=0, out_ready=1):
  - 16'h5555 → out_data 8'hFF, error 0.
  - 16'hAAAA → 8'h00.
  - 16'h6996 → 8'h96.
  - Each appears 2 edges after accept.
- Polarity (POLARITY=1): 16'h5555 → 8'h00; 16'hAAAA → 8'hFF.
- Error reporting:
  - 16'h5557 → out_data 8'hFE, out_err_mask 8'h01, out_error 1, err_count 1.
  - Same stimulus with DROP_ON_ERROR=1 → no output word, err_count 1.
- Backpressure (FIFO_DEPTH=4, out_ready=0):
  - Offer 6 consecutive words 16'h5555, 16'hAAAA, … → exactly 4 accepted, in_ready low, fifo_level 4.
  - Raise out_ready → words emerge in order, and the remaining 2 are accepted as space frees.
- Counter:
  - CNT_W=4, 17 errored words → err_count 15.
  - err_count_clr asserted with an errored word on the same edge → err_count 0.
- Reset/enable:
  - Deassert enable with 3 words queued → all 3 drain while in_ready stays 0.
  - Assert rst_n low with 2 words queued → out_valid 0 and fifo_level 0 immediately.
